// File: rtl/riscv_nn_div_pkg.sv
// riscv_nn_div_pkg: opcodes, controller states and helpers shared by the divider sequencer.
package riscv_nn_div_pkg;

    typedef enum logic [1:0] {OP_UDIV = 2'd0, OP_DIV = 2'd1, OP_UREM = 2'd2, OP_REM = 2'd3} div_op_e;

    typedef enum logic [2:0] {S_IDLE, S_NORM, S_ISSUE, S_WAIT, S_DRAIN} div_state_e;

    localparam int DIV_NUM_REQ = 4;
    localparam int DIV_ID_W = $clog2(DIV_NUM_REQ);

    function automatic int div_id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic logic div_is_signed(input logic [1:0] op);
        return (op == OP_DIV) || (op == OP_REM);
    endfunction

endpackage

// File: rtl/riscv_nn_div_norm.sv
// riscv_nn_div_norm: divisor normalization (leading-bit count, pre-shift, iteration count, flags).
module riscv_nn_div_norm
    import riscv_nn_div_pkg::*;
#(
    parameter int C_WIDTH     = 32,
    parameter int C_LOG_WIDTH = 6
) (
    input  logic [C_WIDTH-1:0]     op_b,
    input  logic [1:0]             op,
    output logic [C_WIDTH-1:0]     op_b_norm,
    output logic [C_LOG_WIDTH-1:0] shift,
    output logic                   is_zero,
    output logic                   sign
);

    logic                   sgn;
    logic                   run;
    logic [C_LOG_WIDTH-1:0] cnt;
    logic [C_LOG_WIDTH-1:0] s;

    assign sgn     = div_is_signed(op);
    assign is_zero = (op_b == '0);
    assign sign    = sgn & op_b[C_WIDTH-1];

    // Signed ops count copies of the sign bit, so the count is at least one.
    always_comb begin
        cnt = '0;
        run = 1'b1;
        for (int i = C_WIDTH - 1; i >= 0; i--) begin
            run = run && (op_b[i] == (sgn & op_b[C_WIDTH-1]));
            cnt = cnt + C_LOG_WIDTH'(run);
        end
        s = sgn ? cnt - 1'b1 : (is_zero ? C_LOG_WIDTH'(C_WIDTH - 1) : cnt);
    end

    assign op_b_norm = op_b << s;
    assign shift     = sgn ? s : s + 1'b1;

endmodule

// File: rtl/riscv_nn_div_ctrl.sv
// riscv_nn_div_ctrl: round-robin sequencer sharing one serial divider among several requesters.
module riscv_nn_div_ctrl
    import riscv_nn_div_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int C_WIDTH     = 32,
    parameter int C_LOG_WIDTH = 6
) (
    input  logic                       Clk_CI,
    input  logic                       Rst_RI,
    input  logic [NUM_REQ-1:0]         ReqVld_SI,
    output logic [NUM_REQ-1:0]         ReqRdy_SO,
    input  logic [NUM_REQ*C_WIDTH-1:0] ReqOpA_DI,
    input  logic [NUM_REQ*C_WIDTH-1:0] ReqOpB_DI,
    input  logic [NUM_REQ*2-1:0]       ReqOpCode_SI,
    output logic [NUM_REQ-1:0]         RespVld_SO,
    input  logic [NUM_REQ-1:0]         RespRdy_SI,
    output logic [C_WIDTH-1:0]         Resp_DO,
    input  logic                       Flush_SI,
    output logic                       Busy_SO,
    output logic [C_WIDTH-1:0]         DivOpA_DO,
    output logic [C_WIDTH-1:0]         DivOpB_DO,
    output logic [C_LOG_WIDTH-1:0]     DivOpBShift_DO,
    output logic                       DivOpBIsZero_SO,
    output logic                       DivOpBSign_SO,
    output logic [1:0]                 DivOpCode_SO,
    output logic                       DivInVld_SO,
    input  logic                       DivOutVld_SI,
    input  logic [C_WIDTH-1:0]         DivRes_DI,
    output logic                       DivOutRdy_SO
);

    localparam int ID_W = div_id_w(NUM_REQ);

    div_state_e             state_q, state_d;
    logic [ID_W-1:0]        ptr_q, id_q, gnt_id, off;
    logic [NUM_REQ-1:0]     rot;
    logic                   found, grant, first_q, out_vld, done;
    logic [C_WIDTH-1:0]     a_q, b_q, norm_b;
    logic [1:0]             op_q;
    logic [C_LOG_WIDTH-1:0] norm_shift;
    logic                   norm_zero, norm_sign;

    riscv_nn_div_norm #(.C_WIDTH(C_WIDTH), .C_LOG_WIDTH(C_LOG_WIDTH)) u_norm (
        .op_b     (b_q),
        .op       (op_q),
        .op_b_norm(norm_b),
        .shift    (norm_shift),
        .is_zero  (norm_zero),
        .sign     (norm_sign)
    );

    // Rotate so the pointer sits at bit 0, then take the lowest set bit.
    always_comb begin
        rot = NUM_REQ'({ReqVld_SI, ReqVld_SI} >> ptr_q);
        found = |rot;
        off = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--)
            if (rot[i]) off = ID_W'(i);
        gnt_id = ID_W'((int'(ptr_q) + int'(off)) % NUM_REQ);
    end

    assign grant     = (state_q == S_IDLE) && found && !Flush_SI && !Rst_RI;
    assign ReqRdy_SO = grant ? NUM_REQ'(1) << gnt_id : '0;

    // The divider still shows its idle-valid in the first WAIT/DRAIN cycle.
    assign out_vld      = DivOutVld_SI && !first_q;
    assign done         = (state_q == S_WAIT) && out_vld && RespRdy_SI[id_q];
    assign RespVld_SO   = ((state_q == S_WAIT) && out_vld) ? NUM_REQ'(1) << id_q : '0;
    assign Resp_DO      = (state_q == S_WAIT) ? DivRes_DI : '0;
    assign DivOutRdy_SO = !first_q && (((state_q == S_WAIT) && RespRdy_SI[id_q]) || (state_q == S_DRAIN));
    assign DivInVld_SO  = (state_q == S_ISSUE);
    assign Busy_SO      = (state_q != S_IDLE);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  state_d = grant ? S_NORM : S_IDLE;
            S_NORM:  state_d = Flush_SI ? S_IDLE : S_ISSUE;
            S_ISSUE: state_d = Flush_SI ? S_DRAIN : S_WAIT;
            S_WAIT:  state_d = Flush_SI ? S_DRAIN : (done ? S_IDLE : S_WAIT);
            S_DRAIN: state_d = out_vld ? S_IDLE : S_DRAIN;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk_CI) begin
        if (Rst_RI) begin
            state_q         <= S_IDLE;
            ptr_q           <= '0;
            id_q            <= '0;
            first_q         <= 1'b0;
            a_q             <= '0;
            b_q             <= '0;
            op_q            <= '0;
            DivOpA_DO       <= '0;
            DivOpB_DO       <= '0;
            DivOpBShift_DO  <= '0;
            DivOpBIsZero_SO <= 1'b0;
            DivOpBSign_SO   <= 1'b0;
            DivOpCode_SO    <= '0;
        end else begin
            state_q <= state_d;
            first_q <= (state_d == S_WAIT || state_d == S_DRAIN) && (state_d != state_q);
            if (grant) begin
                ptr_q <= ID_W'((int'(gnt_id) + 1) % NUM_REQ);
                id_q  <= gnt_id;
                a_q   <= ReqOpA_DI[gnt_id*C_WIDTH +: C_WIDTH];
                b_q   <= ReqOpB_DI[gnt_id*C_WIDTH +: C_WIDTH];
                op_q  <= ReqOpCode_SI[gnt_id*2 +: 2];
            end
            if (state_q == S_NORM) begin
                DivOpA_DO       <= a_q;
                DivOpB_DO       <= norm_b;
                DivOpBShift_DO  <= norm_shift;
                DivOpBIsZero_SO <= norm_zero;
                DivOpBSign_SO   <= norm_sign;
                DivOpCode_SO    <= op_q;
            end
        end
    end

endmodule

// File: tb/tb_riscv_nn_div_ctrl.sv
// tb_riscv_nn_div_ctrl: directed bench with a behavioural serial divider behind the controller.
module tb_riscv_nn_div_ctrl;
    import riscv_nn_div_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_vld, req_rdy, resp_vld, resp_rdy;
    logic [31:0] opa[4], opb[4];
    logic [1:0]  opc[4];
    logic [127:0] opa_flat, opb_flat;
    logic [7:0]  opc_flat;
    logic [31:0] resp, div_a, div_b, div_res;
    logic [5:0]  div_shift;
    logic [1:0]  div_op;
    logic        flush, busy, div_zero, div_sign, div_in_vld, div_out_vld, div_out_rdy;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    assign opa_flat = {opa[3], opa[2], opa[1], opa[0]};
    assign opb_flat = {opb[3], opb[2], opb[1], opb[0]};
    assign opc_flat = {opc[3], opc[2], opc[1], opc[0]};

    riscv_nn_div_ctrl #(.NUM_REQ(4), .C_WIDTH(32), .C_LOG_WIDTH(6)) dut (
        .Clk_CI(clk), .Rst_RI(rst),
        .ReqVld_SI(req_vld), .ReqRdy_SO(req_rdy),
        .ReqOpA_DI(opa_flat), .ReqOpB_DI(opb_flat), .ReqOpCode_SI(opc_flat),
        .RespVld_SO(resp_vld), .RespRdy_SI(resp_rdy), .Resp_DO(resp),
        .Flush_SI(flush), .Busy_SO(busy),
        .DivOpA_DO(div_a), .DivOpB_DO(div_b), .DivOpBShift_DO(div_shift),
        .DivOpBIsZero_SO(div_zero), .DivOpBSign_SO(div_sign), .DivOpCode_SO(div_op),
        .DivInVld_SO(div_in_vld), .DivOutVld_SI(div_out_vld), .DivRes_DI(div_res),
        .DivOutRdy_SO(div_out_rdy)
    );

    // Divider model: recovers the raw divisor from the normalized form, so bad normalization shows up as a wrong result.
    function automatic logic [31:0] ref_div(input logic [1:0] op, input logic [31:0] a, input logic [31:0] nb,
                                            input logic [5:0] sh, input logic z);
        logic [31:0] b;
        if (z) return op[1] ? a : 32'hFFFFFFFF;
        b = op[0] ? 32'($signed(nb) >>> sh) : nb >> (sh - 6'd1);
        if (op[0] && a == 32'h80000000 && b == 32'hFFFFFFFF) return op[1] ? 32'h0 : a;
        case (op)
            OP_UDIV: return a / b;
            OP_DIV:  return 32'($signed(a) / $signed(b));
            OP_UREM: return a % b;
            default: return 32'($signed(a) % $signed(b));
        endcase
    endfunction

    int          dv_st, dv_cnt;
    logic [31:0] dv_res;

    always @(posedge clk) begin
        if (rst) dv_st <= 0;
        else case (dv_st)
            0: if (div_in_vld) begin
                dv_st  <= 1;
                dv_cnt <= int'(div_shift);
                dv_res <= ref_div(div_op, div_a, div_b, div_shift, div_zero);
            end
            1: dv_st <= 2;
            2: if (dv_cnt == 0) dv_st <= 3; else dv_cnt <= dv_cnt - 1;
            default: if (div_out_rdy) dv_st <= 0;
        endcase
    end

    assign div_out_vld = (dv_st != 2);
    assign div_res     = (dv_st == 3) ? dv_res : 32'hDEADBEEF;

    task automatic do_op(input int r, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] nb, input logic [5:0] sh, input logic [1:0] fl, input logic [31:0] res);
        int k;
        opa[r] = a; opb[r] = b; opc[r] = op; req_vld[r] = 1'b1;
        #1;
        k = 0;
        while (req_rdy == 4'b0 && k < 60) begin @(negedge clk); k++; end
        checks++;
        if (req_rdy !== (4'b1 << r)) begin errors++; $display("FAIL grant r%0d got %b want %b", r, req_rdy, 4'b1 << r); end
        @(negedge clk);
        req_vld[r] = 1'b0;
        checks++;
        if ({busy, div_in_vld} !== 2'b10) begin errors++; $display("FAIL norm_state got %b want 10", {busy, div_in_vld}); end
        @(negedge clk);
        checks++;
        if ({div_in_vld, div_a, div_b, div_shift, div_zero, div_sign, div_op} !== {1'b1, a, nb, sh, fl, op}) begin
            errors++;
            $display("FAIL issue vld=%b a=%h b=%h sh=%0d zs=%b op=%0d want a=%h b=%h sh=%0d zs=%b op=%0d",
                     div_in_vld, div_a, div_b, div_shift, {div_zero, div_sign}, div_op, a, nb, sh, fl, op);
        end
        k = 0;
        do begin @(negedge clk); k++; end while (resp_vld == 4'b0 && k < 100);
        checks++;
        if (resp_vld !== (4'b1 << r)) begin errors++; $display("FAIL resp_vld got %b want %b", resp_vld, 4'b1 << r); end
        checks++;
        if (resp !== res) begin errors++; $display("FAIL resp_data got %h want %h", resp, res); end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL idle_after_resp busy got %b want 0", busy); end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({req_rdy, resp_vld, div_in_vld, div_out_rdy, busy} !== 11'b0) begin
            errors++; $display("FAIL reset_ctrl got %b want 0", {req_rdy, resp_vld, div_in_vld, div_out_rdy, busy});
        end
        checks++;
        if ({div_a, div_b, div_shift, div_zero, div_sign, div_op} !== 74'b0) begin
            errors++; $display("FAIL reset_data a=%h b=%h sh=%0d want 0", div_a, div_b, div_shift);
        end
        checks++;
        if (resp !== 32'h0) begin errors++; $display("FAIL reset_resp got %h want 0", resp); end
    endtask

    task automatic test_basic();
        do_op(0, OP_UDIV, 32'd100, 32'd7, 32'hE0000000, 6'd30, 2'b00, 32'd14);
        do_op(0, OP_UREM, 32'd100, 32'd7, 32'hE0000000, 6'd30, 2'b00, 32'd2);
        do_op(0, OP_DIV,  32'hFFFFFF9C, 32'd7, 32'h70000000, 6'd28, 2'b00, 32'hFFFFFFF2);
        do_op(0, OP_REM,  32'hFFFFFF9C, 32'd7, 32'h70000000, 6'd28, 2'b00, 32'hFFFFFFFE);
    endtask

    task automatic test_special();
        do_op(0, OP_UDIV, 32'd5, 32'd0, 32'h0, 6'd32, 2'b10, 32'hFFFFFFFF);
        do_op(0, OP_UREM, 32'd5, 32'd0, 32'h0, 6'd32, 2'b10, 32'd5);
        do_op(0, OP_DIV,  32'h80000000, 32'hFFFFFFFF, 32'h80000000, 6'd31, 2'b01, 32'h80000000);
        do_op(0, OP_REM,  32'h80000000, 32'hFFFFFFFF, 32'h80000000, 6'd31, 2'b01, 32'h0);
    endtask

    task automatic test_fairness();
        logic [31:0] exp_res[4];
        int k, r;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        opa[0] = 32'd20; opb[0] = 32'd4; opc[0] = OP_UDIV; exp_res[0] = 32'd5;
        opa[1] = 32'd21; opb[1] = 32'd3; opc[1] = OP_UDIV; exp_res[1] = 32'd7;
        opa[2] = 32'd99; opb[2] = 32'd9; opc[2] = OP_UDIV; exp_res[2] = 32'd11;
        opa[3] = 32'd64; opb[3] = 32'd8; opc[3] = OP_UDIV; exp_res[3] = 32'd8;
        req_vld = 4'hF;
        #1;
        for (int g = 0; g < 5; g++) begin
            r = g % 4;
            k = 0;
            while (req_rdy == 4'b0 && k < 60) begin @(negedge clk); k++; end
            checks++;
            if (req_rdy !== (4'b1 << r)) begin errors++; $display("FAIL rr_grant%0d got %b want %b", g, req_rdy, 4'b1 << r); end
            k = 0;
            do begin @(negedge clk); k++; end while (resp_vld == 4'b0 && k < 100);
            checks++;
            if ({resp_vld, resp} !== {4'b1 << r, exp_res[r]}) begin
                errors++; $display("FAIL rr_resp%0d got %b/%h want %b/%h", g, resp_vld, resp, 4'b1 << r, exp_res[r]);
            end
        end
        req_vld = 4'b0;
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        int k;
        opa[1] = 32'd77;   opb[1] = 32'd7;  opc[1] = OP_UDIV;
        opa[0] = 32'd1000; opb[0] = 32'd10; opc[0] = OP_UDIV;
        resp_rdy[1] = 1'b0;
        req_vld = 4'b0011;
        #1;
        k = 0;
        while (req_rdy == 4'b0 && k < 60) begin @(negedge clk); k++; end
        checks++;
        if (req_rdy !== 4'b0010) begin errors++; $display("FAIL bp_grant got %b want 0010", req_rdy); end
        @(negedge clk);
        req_vld[1] = 1'b0;
        k = 0;
        do begin @(negedge clk); k++; end while (resp_vld == 4'b0 && k < 100);
        for (int c = 0; c < 5; c++) begin
            checks++;
            if ({resp_vld, resp, div_out_rdy, req_rdy} !== {4'b0010, 32'd11, 1'b0, 4'b0}) begin
                errors++; $display("FAIL bp_hold%0d vld=%b data=%h drdy=%b grant=%b want 0010/%h/0/0000",
                                   c, resp_vld, resp, div_out_rdy, req_rdy, 32'd11);
            end
            @(negedge clk);
        end
        resp_rdy[1] = 1'b1;
        #1;
        checks++;
        if (div_out_rdy !== 1'b1) begin errors++; $display("FAIL bp_release drdy got %b want 1", div_out_rdy); end
        @(negedge clk);
        checks++;
        if (req_rdy !== 4'b0001) begin errors++; $display("FAIL bp_next_grant got %b want 0001", req_rdy); end
        @(negedge clk);
        req_vld[0] = 1'b0;
        k = 0;
        do begin @(negedge clk); k++; end while (resp_vld == 4'b0 && k < 100);
        checks++;
        if ({resp_vld, resp} !== {4'b0001, 32'd100}) begin
            errors++; $display("FAIL bp_second got %b/%h want 0001/%h", resp_vld, resp, 32'd100);
        end
        @(negedge clk);
    endtask

    task automatic test_flush();
        int k;
        logic saw_vld, saw_rdy;
        opa[2] = 32'd50; opb[2] = 32'd5; opc[2] = OP_UDIV;
        req_vld[2] = 1'b1;
        #1;
        k = 0;
        while (req_rdy == 4'b0 && k < 60) begin @(negedge clk); k++; end
        @(negedge clk);
        req_vld[2] = 1'b0;
        repeat (3) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        saw_vld = 1'b0;
        saw_rdy = 1'b0;
        k = 0;
        while (busy && k < 100) begin
            saw_vld |= (resp_vld != 4'b0);
            saw_rdy |= div_out_rdy;
            @(negedge clk);
            k++;
        end
        checks++;
        if (saw_vld !== 1'b0) begin errors++; $display("FAIL flush_resp saw_vld got %b want 0", saw_vld); end
        checks++;
        if ({busy, saw_rdy} !== 2'b01) begin errors++; $display("FAIL flush_drain busy/rdy got %b want 01", {busy, saw_rdy}); end
        do_op(1, OP_UDIV, 32'd1000, 32'd10, 32'hA0000000, 6'd29, 2'b00, 32'd100);
    endtask

    task automatic test_reset_mid();
        int k;
        opa[3] = 32'd100; opb[3] = 32'd7; opc[3] = OP_UDIV;
        req_vld[3] = 1'b1;
        #1;
        k = 0;
        while (req_rdy == 4'b0 && k < 60) begin @(negedge clk); k++; end
        @(negedge clk);
        req_vld[3] = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({req_rdy, resp_vld, div_in_vld, div_out_rdy, busy} !== 11'b0) begin
            errors++; $display("FAIL rst_mid_ctrl got %b want 0", {req_rdy, resp_vld, div_in_vld, div_out_rdy, busy});
        end
        checks++;
        if ({div_a, div_b, div_shift, div_zero, div_sign, div_op, resp} !== 106'b0) begin
            errors++; $display("FAIL rst_mid_data a=%h b=%h sh=%0d resp=%h want 0", div_a, div_b, div_shift, resp);
        end
        rst = 1'b0;
        @(negedge clk);
        do_op(3, OP_UREM, 32'd100, 32'd7, 32'hE0000000, 6'd30, 2'b00, 32'd2);
    endtask

    initial begin
        rst = 1'b1;
        req_vld = 4'b0;
        resp_rdy = 4'hF;
        flush = 1'b0;
        for (int i = 0; i < 4; i++) begin opa[i] = '0; opb[i] = '0; opc[i] = '0; end
        @(negedge clk);
        test_reset();
        test_basic();
        test_special();
        test_fairness();
        test_backpressure();
        test_flush();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

endmodule

// File: doc/riscv_nn_div_ctrl.md
# riscv_nn_div_ctrl

Sequencer and round-robin arbiter that shares one serial divider (`riscv_nn_alu_div`) among `NUM_REQ` requesters in the NN cluster. It accepts one request at a time. It computes the divisor normalization the divider expects (pre-shifted `OpB`, iteration count, zero and sign flags), issues the operation, and routes the result back to the originating requester. It also provides a flush that abandons an in-flight operation without corrupting the divider.

## Interface
- `NUM_REQ`, 4: number of requesters, ≥2
- `C_WIDTH`, 32: operand width
- `C_LOG_WIDTH`, 6: `$clog2(C_WIDTH+1)`
- `Clk_CI` in 1: clock
- `Rst_RI` in 1: one clock; reset is synchronous and active-high
- `ReqVld_SI` in NUM_REQ: per-requester request valid, held until accepted
- `ReqRdy_SO` out NUM_REQ: one-hot accept strobe
- `ReqOpA_DI`, `ReqOpB_DI` in NUM_REQ×C_WIDTH: dividend and divisor
- `ReqOpCode_SI` in NUM_REQ×2: 0 udiv, 1 div, 2 urem, 3 rem
- `RespVld_SO` out NUM_REQ: one-hot result valid
- `RespRdy_SI` in NUM_REQ: result accept
- `Resp_DO` out C_WIDTH: result, shared bus
- `Flush_SI` in 1: abandon current operation
- `Busy_SO` out 1: state ≠ IDLE
- `DivOpA_DO`, `DivOpB_DO` out C_WIDTH: operands to the divider
- `DivOpBShift_DO` out C_LOG_WIDTH: divider iteration count
- `DivOpBIsZero_SO`, `DivOpBSign_SO` out 1: divisor flags
- `DivOpCode_SO` out 2: opcode to the divider
- `DivInVld_SO` out 1: issue strobe
- `DivOutVld_SI`, `DivRes_DI` in: divider result handshake and data
- `DivOutRdy_SO` out 1: result accept to the divider

## Operation
- **States:** IDLE, NORM, ISSUE, WAIT, DRAIN.
- **IDLE**
  - Round-robin arbitration over `ReqVld_SI`, starting from pointer `Ptr`.
  - The winner `g` gets `ReqRdy_SO[g]`=1 for one cycle. Its operands, opcode and ID are captured.
  - `Ptr` advances to `g+1` mod `NUM_REQ`. The next state is NORM.
  - No grant is made while `Flush_SI`=1.
- **NORM**
  - Registers the normalized divisor computed from the captured request:
    - `DivOpBIsZero_SO` = (B==0).
    - `DivOpBSign_SO` = opcode[0] & B[31]. The sign flag is gated to 0 for unsigned ops.
  - Unsigned ops:
    - s = clz(B), with B==0 giving s=31.
    - `DivOpB_DO` = B<<s.
    - `DivOpBShift_DO` = s+1.
  - Signed ops:
    - s = (count of leading bits equal to B[31]) − 1, with B==0 giving s=31.
    - `DivOpB_DO` = B<<s.
    - `DivOpBShift_DO` = s.
  - `DivOpA_DO` = A.
  - The next state is ISSUE.
- **ISSUE:** `DivInVld_SO`=1 for exactly one cycle. The next state is WAIT.
- **WAIT**
  - `RespVld_SO[id]` = `DivOutVld_SI`, and `Resp_DO` = `DivRes_DI` (combinational pass-through).
  - `DivOutRdy_SO` = `RespRdy_SI[id]`.
  - When both are high, the next state is IDLE.
  - `DivOutVld_SI` is not sampled in the first WAIT cycle, because the divider is still leaving its idle-valid state.
- **Flush**
  - In NORM: return to IDLE without issuing. The requester receives no response.
  - In ISSUE or WAIT: go to DRAIN.
    - If the flush arrives in ISSUE, the issue still happens.
    - In WAIT, a flush cycle coinciding with a `DivOutVld_SI`&`RespRdy_SI` completion goes to DRAIN, not IDLE.
  - **DRAIN:**
    - `RespVld_SO`=0.
    - `DivOutRdy_SO`=1 from the second cycle on.
    - Returns to IDLE on `DivOutVld_SI`.
- **End-to-end special cases:**
  - Divide by zero: div and udiv give all-ones; rem and urem give A.
  - Signed overflow: −2^31 / −1 gives −2^31; rem gives 0.

## Timing
- **Reset:** state IDLE and `Ptr`=0.
  - All `ReqRdy_SO`, `RespVld_SO`, `DivInVld_SO` and `DivOutRdy_SO` are 0.
  - All `Div*_DO`/`Div*_SO` data outputs, `Resp_DO` and `Busy_SO` are 0.
  - Reset mid-operation returns to IDLE immediately. The divider must be reset in the same cycle.
- **Latency:** accept at cycle T, NORM at T+1, `DivInVld_SO` at T+2. The result is valid T+3+(`DivOpBShift_DO`+1)+1 at the earliest.
- **Throughput and backpressure:**
  - Next accept is possible in the cycle after the response handshake completes. Back-to-back throughput is one op per (latency+1).
  - `RespVld_SO` holds with stable `Resp_DO` until `RespRdy_SI`. `RespRdy_SI` may be high before valid.
- **Requesters:** a requester dropping `ReqVld_SI` before grant is legal and simply loses arbitration. Data must be stable while valid.

## Structure
- **Package `riscv_nn_div_pkg`:**
  - Opcode enum (UDIV, DIV, UREM, REM).
  - Controller state enum.
  - `DIV_ID_W` = `$clog2(NUM_REQ)`.
- **Sub-module `riscv_nn_div_norm`:** combinational leading-bit counter, shifter, shift/zero/sign generation. It is used in NORM.
- **Arbiter:** round-robin logic stays inline (pointer plus rotate-priority encode).

## Test plan
- **Basic ops, requester 0:** 100/7 → udiv 14, urem 2; −100/7 → div −14, rem −2; respond to requester 0 only.
- **Zero divisor and overflow:** udiv 5/0 → 0xFFFFFFFF; urem 5/0 → 5; div 0x80000000/0xFFFFFFFF → 0x80000000, rem → 0.
- **Arbitration fairness:** all 4 requesters valid continuously → grant order 0, 1, 2, 3, 0; each response carries its own operands' result.
- **Backpressure:** hold `RespRdy_SI` low for 5 cycles after valid → `Resp_DO` stable; `DivOutRdy_SO`=0; no new grant until the handshake completes.
- **Flush mid-operation:** `Flush_SI` in WAIT on requester 2 → no `RespVld_SO`; the divider is drained; the next request 1000/10 → 100, correct.
- **Reset mid-operation:** assert `Rst_RI` in WAIT → all outputs 0 next cycle; the following request completes correctly.
